// File: rtl/bp_fe_mock_fe_gen_pkg.sv
// FE/BE interface types shared by the mock front end and its users.
// Struct widths are fixed by the single supported parameter configuration.
package bp_fe_mock_fe_gen_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    localparam int vaddr_width_gp = 39;
    localparam int instr_width_gp = 32;

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_attaboy              = 3'd3,
        e_op_icache_fence         = 3'd4
    } bp_fe_command_queue_opcodes_e;

    typedef enum logic [0:0] {
        e_fe_fetch     = 1'b0,
        e_fe_exception = 1'b1
    } bp_fe_queue_type_e;

    typedef enum logic [1:0] {
        e_instr_page_fault   = 2'd0,
        e_instr_access_fault = 2'd1,
        e_icache_miss        = 2'd2,
        e_itlb_miss          = 2'd3
    } bp_fe_exception_code_e;

    typedef struct packed {
        bp_fe_command_queue_opcodes_e opcode;
        logic [vaddr_width_gp-1:0]    vaddr;
    } bp_fe_cmd_s;

    typedef struct packed {
        bp_fe_queue_type_e         msg_type;
        bp_fe_exception_code_e     exception_code;
        logic [vaddr_width_gp-1:0] vaddr;
        logic [instr_width_gp-1:0] instr;
    } bp_fe_queue_s;

    localparam int fe_cmd_width_gp   = $bits(bp_fe_cmd_s);
    localparam int fe_queue_width_gp = $bits(bp_fe_queue_s);

    function automatic int bp_vaddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return vaddr_width_gp;
            default:          return vaddr_width_gp;
        endcase
    endfunction

endpackage

// File: rtl/bp_fe_mock_perf_cnt.sv
// Purpose: pair of wrapping 32-bit event counters (fetch, miss).
// Latency: count visible the cycle after its enable; no backpressure.
module bp_fe_mock_perf_cnt (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        fetch_en_i,
    input  logic        miss_en_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] miss_cnt_o
);

    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] miss_cnt_q,  miss_cnt_d;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(fetch_en_i);
        miss_cnt_d  = miss_cnt_q  + 32'(miss_en_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            fetch_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: rtl/bp_fe_mock_fe_gen.sv
// Purpose: mock front end emitting fetch/miss messages driven by BE commands.
// Latency: message presented the cycle after the command; commands always consumed and pre-empt messages.
module bp_fe_mock_fe_gen
    import bp_fe_mock_fe_gen_pkg::*;
#(
    parameter bp_params_e  bp_params_p  = e_bp_default_cfg,
    parameter int          line_bytes_p = 64,
    parameter logic [31:0] instr_seed_p = 32'h0000_0013
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic [fe_cmd_width_gp-1:0]   fe_cmd_i,
    input  logic                         fe_cmd_v_i,
    output logic                         fe_cmd_yumi_o,
    output logic [fe_queue_width_gp-1:0] fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         fe_queue_ready_i,
    output logic [31:0]                  fetch_cnt_o,
    output logic [31:0]                  miss_cnt_o
);

    localparam int vaddr_width_p = bp_vaddr_width(bp_params_p);
    localparam int instr_width_p = instr_width_gp;
    localparam int line_offs_lp  = $clog2(line_bytes_p);
    localparam int tag_width_lp  = vaddr_width_p - line_offs_lp;

    typedef enum logic [1:0] {
        e_wait  = 2'd0,
        e_fetch = 2'd1,
        e_miss  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [vaddr_width_p-1:0] pc_q, pc_d;
    logic [tag_width_lp-1:0]  tag_q, tag_d;
    logic                     tag_v_q, tag_v_d;

    bp_fe_cmd_s               cmd;
    bp_fe_queue_s             queue;
    logic [tag_width_lp-1:0]  pc_line, cmd_line;
    logic                     fetch_hit;
    logic                     fetch_inc, miss_inc;

    assign cmd       = fe_cmd_i;
    assign pc_line   = pc_q[vaddr_width_p-1:line_offs_lp];
    assign cmd_line  = cmd.vaddr[vaddr_width_p-1:line_offs_lp];
    assign fetch_hit = tag_v_q && (pc_line == tag_q);

    // Gate with reset so a command held valid during reset is not reported consumed.
    assign fe_cmd_yumi_o = fe_cmd_v_i & reset_n_i;
    assign fe_queue_o    = queue;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tag_d        = tag_q;
        tag_v_d      = tag_v_q;
        fetch_inc    = 1'b0;
        miss_inc     = 1'b0;
        queue        = '0;
        fe_queue_v_o = 1'b0;

        if (state_q == e_fetch) begin
            if (fetch_hit) begin
                queue.msg_type = e_fe_fetch;
                queue.vaddr    = pc_q;
                queue.instr    = pc_q[instr_width_p-1:0] ^ instr_seed_p;
            end else begin
                queue.msg_type       = e_fe_exception;
                queue.exception_code = e_icache_miss;
                queue.vaddr          = pc_q;
            end
            fe_queue_v_o = !fe_cmd_v_i;
        end

        if (fe_cmd_v_i) begin
            case (cmd.opcode)
                e_op_state_reset: begin
                    pc_d    = cmd.vaddr;
                    tag_v_d = 1'b0;
                    state_d = e_fetch;
                end
                e_op_pc_redirection: begin
                    if (state_q != e_wait) begin
                        pc_d    = cmd.vaddr;
                        state_d = e_fetch;
                    end
                end
                e_op_icache_fill_response: begin
                    // Only a fill for the line we are stalled on unblocks the miss.
                    if (state_q == e_miss && cmd_line == pc_line) begin
                        tag_d   = pc_line;
                        tag_v_d = 1'b1;
                        state_d = e_fetch;
                    end
                end
                default: ;
            endcase
        end else if (fe_queue_v_o && fe_queue_ready_i) begin
            if (fetch_hit) begin
                pc_d      = pc_q + vaddr_width_p'(4);
                fetch_inc = 1'b1;
            end else begin
                state_d  = e_miss;
                miss_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_wait;
            pc_q    <= '0;
            tag_q   <= '0;
            tag_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= tag_d;
            tag_v_q <= tag_v_d;
        end
    end

    bp_fe_mock_perf_cnt perf_cnt (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .fetch_en_i  (fetch_inc),
        .miss_en_i   (miss_inc),
        .fetch_cnt_o (fetch_cnt_o),
        .miss_cnt_o  (miss_cnt_o)
    );

endmodule

// File: tb/tb_bp_fe_mock_fe_gen.sv
// Directed bench for the mock front end: fetch/miss sequencing, stalls, redirects, reset, wrap.
`define CHK(t, o, e) chk(t, 128'(o), 128'(e))

module tb_bp_fe_mock_fe_gen;
    import bp_fe_mock_fe_gen_pkg::*;

    logic                         clk_i = 1'b0;
    logic                         reset_n_i;
    logic [fe_cmd_width_gp-1:0]   fe_cmd_i;
    logic                         fe_cmd_v_i;
    logic                         fe_cmd_yumi_o;
    logic [fe_queue_width_gp-1:0] fe_queue_o;
    logic                         fe_queue_v_o;
    logic                         fe_queue_ready_i;
    logic [31:0]                  fetch_cnt_o;
    logic [31:0]                  miss_cnt_o;

    bp_fe_queue_s q;
    assign q = fe_queue_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    bp_fe_mock_fe_gen dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .fe_cmd_i         (fe_cmd_i),
        .fe_cmd_v_i       (fe_cmd_v_i),
        .fe_cmd_yumi_o    (fe_cmd_yumi_o),
        .fe_queue_o       (fe_queue_o),
        .fe_queue_v_o     (fe_queue_v_o),
        .fe_queue_ready_i (fe_queue_ready_i),
        .fetch_cnt_o      (fetch_cnt_o),
        .miss_cnt_o       (miss_cnt_o)
    );

    always @(negedge clk_i) begin
        if (reset_n_i === 1'b1) begin
            total++;
            if (fe_cmd_yumi_o !== fe_cmd_v_i) begin
                bad++;
                $error("FAIL mon_yumi observed=%0b expected=%0b", fe_cmd_yumi_o, fe_cmd_v_i);
            end
        end
        if (fe_cmd_v_i === 1'b1) begin
            total++;
            if (fe_queue_v_o !== 1'b0) begin
                bad++;
                $error("FAIL mon_preempt observed=%0b expected=0", fe_queue_v_o);
            end
        end
        if (reset_n_i === 1'b0) begin
            total++;
            if (fetch_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0 || fe_queue_v_o !== 1'b0) begin
                bad++;
                $error("FAIL mon_reset fetch=%0h miss=%0h v=%0b", fetch_cnt_o, miss_cnt_o, fe_queue_v_o);
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bp_fe_queue_s exp_fetch(input logic [38:0] pc);
        bp_fe_queue_s r;
        r          = '0;
        r.msg_type = e_fe_fetch;
        r.vaddr    = pc;
        r.instr    = pc[31:0] ^ 32'h0000_0013;
        return r;
    endfunction

    function automatic bp_fe_queue_s exp_miss(input logic [38:0] va);
        bp_fe_queue_s r;
        r                = '0;
        r.msg_type       = e_fe_exception;
        r.exception_code = e_icache_miss;
        r.vaddr          = va;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic send(input bp_fe_command_queue_opcodes_e op, input logic [38:0] va);
        bp_fe_cmd_s c;
        c.opcode   = op;
        c.vaddr    = va;
        fe_cmd_i   = c;
        fe_cmd_v_i = 1'b1;
        #1;
        `CHK("cmd_yumi", fe_cmd_yumi_o, 1'b1);
        `CHK("cmd_preempt_v", fe_queue_v_o, 1'b0);
        tick();
        fe_cmd_v_i = 1'b0;
        #1;
    endtask

    initial begin
        reset_n_i        = 1'b1;
        fe_cmd_v_i       = 1'b1;
        fe_cmd_i         = '0;
        fe_queue_ready_i = 1'b1;
        #1 reset_n_i = 1'b0;
        #1;
        `CHK("rst_v", fe_queue_v_o, 1'b0);
        `CHK("rst_yumi", fe_cmd_yumi_o, 1'b0);
        `CHK("rst_fetch_cnt", fetch_cnt_o, 32'd0);
        `CHK("rst_miss_cnt", miss_cnt_o, 32'd0);
        fe_cmd_v_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b1;
        tick();
        tick();
        `CHK("wait_idle_v", fe_queue_v_o, 1'b0);

        send(e_op_pc_redirection, 39'h00_8000_0000);
        `CHK("wait_redirect_drop_v", fe_queue_v_o, 1'b0);
        send(e_op_icache_fill_response, 39'h00_8000_0000);
        tick();
        `CHK("wait_fill_drop_v", fe_queue_v_o, 1'b0);

        send(e_op_state_reset, 39'h00_8000_0000);
        `CHK("sr_miss_v", fe_queue_v_o, 1'b1);
        `CHK("sr_miss_msg", q, exp_miss(39'h00_8000_0000));
        tick();
        `CHK("sr_miss_cnt", miss_cnt_o, 32'd1);
        `CHK("in_miss_v", fe_queue_v_o, 1'b0);
        tick();
        `CHK("in_miss_hold_v", fe_queue_v_o, 1'b0);

        send(e_op_icache_fill_response, 39'h00_8000_0000);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                fe_queue_ready_i = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    `CHK("stall_v", fe_queue_v_o, 1'b1);
                    `CHK("stall_msg", q, exp_fetch(39'h00_8000_0014));
                    `CHK("stall_fetch_cnt", fetch_cnt_o, 32'd5);
                    tick();
                end
                fe_queue_ready_i = 1'b1;
            end
            `CHK("fetch_v", fe_queue_v_o, 1'b1);
            `CHK("fetch_msg", q, exp_fetch(39'h00_8000_0000 + 39'(4 * i)));
            `CHK("fetch_cnt", fetch_cnt_o, 32'(i));
            tick();
        end
        `CHK("line_end_fetch_cnt", fetch_cnt_o, 32'd16);
        `CHK("line_end_v", fe_queue_v_o, 1'b1);
        `CHK("line_end_miss_msg", q, exp_miss(39'h00_8000_0040));
        tick();
        `CHK("line_end_miss_cnt", miss_cnt_o, 32'd2);
        `CHK("line_end_in_miss_v", fe_queue_v_o, 1'b0);

        send(e_op_icache_fill_response, 39'h00_8000_1000);
        `CHK("wrong_fill_v", fe_queue_v_o, 1'b0);
        tick();
        `CHK("wrong_fill_v2", fe_queue_v_o, 1'b0);
        `CHK("wrong_fill_miss_cnt", miss_cnt_o, 32'd2);
        send(e_op_icache_fill_response, 39'h00_8000_0040);
        `CHK("right_fill_v", fe_queue_v_o, 1'b1);
        `CHK("right_fill_msg", q, exp_fetch(39'h00_8000_0040));
        tick();
        `CHK("resume_fetch_cnt", fetch_cnt_o, 32'd17);
        `CHK("resume_msg", q, exp_fetch(39'h00_8000_0044));

        send(e_op_pc_redirection, 39'h00_8000_0100);
        `CHK("redir_no_xfer_cnt", fetch_cnt_o, 32'd17);
        `CHK("redir_v", fe_queue_v_o, 1'b1);
        `CHK("redir_miss_msg", q, exp_miss(39'h00_8000_0100));
        tick();
        `CHK("redir_miss_cnt", miss_cnt_o, 32'd3);
        `CHK("redir_in_miss_v", fe_queue_v_o, 1'b0);

        reset_n_i = 1'b0;
        #1;
        `CHK("miss_rst_v", fe_queue_v_o, 1'b0);
        `CHK("miss_rst_fetch_cnt", fetch_cnt_o, 32'd0);
        `CHK("miss_rst_miss_cnt", miss_cnt_o, 32'd0);
        tick();
        reset_n_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            `CHK("post_rst_quiet_v", fe_queue_v_o, 1'b0);
        end
        `CHK("post_rst_miss_cnt", miss_cnt_o, 32'd0);

        send(e_op_state_reset, 39'h7F_FFFF_FFFC);
        `CHK("top_miss_msg", q, exp_miss(39'h7F_FFFF_FFFC));
        tick();
        `CHK("top_miss_cnt", miss_cnt_o, 32'd1);
        send(e_op_pc_redirection, 39'h7F_FFFF_FFFC);
        `CHK("miss_redir_v", fe_queue_v_o, 1'b1);
        `CHK("miss_redir_msg", q, exp_miss(39'h7F_FFFF_FFFC));
        tick();
        `CHK("miss_redir_cnt", miss_cnt_o, 32'd2);
        send(e_op_icache_fill_response, 39'h7F_FFFF_FFC0);
        `CHK("top_fetch_msg", q, exp_fetch(39'h7F_FFFF_FFFC));
        `CHK("top_fetch_instr", q.instr, 32'hFFFF_FFEF);
        tick();
        `CHK("wrap_fetch_cnt", fetch_cnt_o, 32'd1);
        `CHK("wrap_v", fe_queue_v_o, 1'b1);
        `CHK("wrap_miss_msg", q, exp_miss(39'h0));
        tick();
        `CHK("wrap_miss_cnt", miss_cnt_o, 32'd3);
        `CHK("wrap_in_miss_v", fe_queue_v_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
